// File: rtl/iir_filter_mc_if.sv
// Sample/clear/output bundle for iir_filter_mc.
// The DUT takes the slave modport. The driving side takes the master modport.
interface iir_filter_mc_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int CW = $clog2(CHANNELS);

  logic                       in_valid;
  logic [CW-1:0]              in_channel;
  logic signed [WIDTH-1:0]    in_sample;
  logic [CHANNELS-1:0]        clear_mask;
  logic                       out_valid;
  logic [CW-1:0]              out_channel;
  logic signed [WIDTH-1:0]    out_sample;

  modport master (
    output in_valid, in_channel, in_sample, clear_mask,
    input  out_valid, out_channel, out_sample
  );

  modport slave (
    input  in_valid, in_channel, in_sample, clear_mask,
    output out_valid, out_channel, out_sample
  );
endinterface

// File: rtl/iir_filter_mc.sv
// Multi-channel first-order IIR: y += (x - y) >>> SHIFT, two-stage pipeline with same-channel forwarding.
// Define IIR_FILTER_PRIME_EN so that the first sample on an unprimed channel loads y directly.
module iir_filter_mc #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SHIFT    = 4
) (
  input  logic            clk,
  input  logic            reset,
  iir_filter_mc_if.slave  bus
);
  localparam int CW = $clog2(CHANNELS);
  localparam int DW = WIDTH + 1;

  logic signed [WIDTH-1:0] y_cur [CHANNELS];
`ifdef IIR_FILTER_PRIME_EN
  logic [CHANNELS-1:0]     p_cur;
  logic                    s1_primed;
`endif

  logic                    s1_hit;
  logic                    s1_fwd;
  logic                    s1_clr;
  logic signed [WIDTH-1:0] s1_y;
  logic signed [DW-1:0]    s1_diff;
  logic signed [DW-1:0]    s1_shifted;
  logic                    shift_msb_unused;

  logic                    s2_valid_q, s2_valid_d;
  logic [CW-1:0]           s2_ch_q, s2_ch_d;
  logic signed [WIDTH-1:0] s2_base_q, s2_base_d;
  logic signed [WIDTH-1:0] s2_step_q, s2_step_d;
  logic signed [WIDTH-1:0] y_new;

  logic                    out_valid_q, out_valid_d;
  logic [CW-1:0]           out_channel_q, out_channel_d;
  logic signed [WIDTH-1:0] out_sample_q, out_sample_d;

  // y_new always lies between y and x, so the WIDTH-bit sum cannot wrap.
  assign y_new            = s2_base_q + s2_step_q;
  assign shift_msb_unused = s1_shifted[WIDTH];

  // Stage 1: pick up y[c], where a clear beats forwarding and forwarding beats stored state.
  always_comb begin
    s1_hit = bus.in_valid && (int'(bus.in_channel) < CHANNELS);
    s1_fwd = s2_valid_q && (s2_ch_q == bus.in_channel);
    s1_clr = bus.clear_mask[bus.in_channel];

    s1_y = y_cur[bus.in_channel];
    if (s1_fwd) s1_y = y_new;
    if (s1_clr) s1_y = '0;

    s1_diff    = {bus.in_sample[WIDTH-1], bus.in_sample} - {s1_y[WIDTH-1], s1_y};
    s1_shifted = s1_diff >>> SHIFT;

    s2_valid_d = s1_hit;
    s2_ch_d    = s2_ch_q;
    s2_base_d  = s2_base_q;
    s2_step_d  = s2_step_q;
    if (s1_hit) begin
      s2_ch_d   = bus.in_channel;
      s2_base_d = s1_y;
      s2_step_d = s1_shifted[WIDTH-1:0];
    end

`ifdef IIR_FILTER_PRIME_EN
    s1_primed = p_cur[bus.in_channel];
    if (s1_fwd) s1_primed = 1'b1;
    if (s1_clr) s1_primed = 1'b0;
    if (s1_hit && !s1_primed) begin
      s2_base_d = bus.in_sample;
      s2_step_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_base_q  <= '0;
      s2_step_q  <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_ch_q    <= s2_ch_d;
      s2_base_q  <= s2_base_d;
      s2_step_q  <= s2_step_d;
    end
  end

  // Per-channel state. A clear wins over a stage-2 write landing in the same cycle.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic                    wr;
    logic signed [WIDTH-1:0] y_q, y_d;

    always_comb begin
      wr  = s2_valid_q && (s2_ch_q == CW'(gi));
      y_d = y_q;
      if (bus.clear_mask[gi]) y_d = '0;
      else if (wr)            y_d = y_new;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) y_q <= '0;
      else       y_q <= y_d;
    end

    assign y_cur[gi] = y_q;

`ifdef IIR_FILTER_PRIME_EN
    logic p_q, p_d;

    always_comb begin
      p_d = p_q;
      if (bus.clear_mask[gi]) p_d = 1'b0;
      else if (wr)            p_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) p_q <= 1'b0;
      else       p_q <= p_d;
    end

    assign p_cur[gi] = p_q;
`endif
  end

  // Stage 2 outputs. The data holds its last value whenever no sample completes.
  always_comb begin
    out_valid_d   = s2_valid_q;
    out_channel_d = out_channel_q;
    out_sample_d  = out_sample_q;
    if (s2_valid_q) begin
      out_channel_d = s2_ch_q;
      out_sample_d  = y_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_sample_q  <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_sample_q  <= out_sample_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_sample  = out_sample_q;

endmodule

// File: doc/iir_filter_mc.md
IIR_FILTER_MC -- requirements
Module: iir_filter_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample and state width, signed two's complement.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent filter channels, minimum 2.
REQ-003 SHALL have parameter SHIFT, default 4: attenuation shift, legal range 0..WIDTH-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_sample and in_channel are valid this cycle.
REQ-007 SHALL have port in_channel, input, $clog2(CHANNELS) bits: channel index of the incoming sample.
REQ-008 SHALL have port in_sample, input, WIDTH bits: signed raw sample.
REQ-009 SHALL have port clear_mask, input, CHANNELS bits: per-channel clear strobe.
REQ-010 SHALL have port out_valid, output, 1 bit: out_sample and out_channel are valid this cycle.
REQ-011 SHALL have port out_channel, output, $clog2(CHANNELS) bits: channel of the output sample.
REQ-012 SHALL have port out_sample, output, WIDTH bits: signed filtered sample.
REQ-013 SHALL be in the clock/reset domain decided as: one clock; reset asynchronous and active-high, ports named clk and reset.

Function
REQ-014 SHALL keep per channel c a state y[c] (WIDTH bits) and a primed flag p[c].
REQ-015 SHALL compute, for an accepted sample x on channel c: y_new = y[c] + ((x - y[c]) >>> SHIFT).
REQ-016 SHALL form the difference at WIDTH+1 bits with an arithmetic (floor) shift; the result SHALL be truncated to WIDTH bits, which is lossless since y_new lies between y[c] and x.
REQ-017 SHALL use a two-stage pipeline: stage 1 reads y[c] and registers the difference; stage 2 adds, writes y[c] and drives the outputs.
REQ-018 SHALL assert out_valid exactly 2 cycles after in_valid, for one cycle per input, with out_sample = y_new and out_channel = c.
REQ-019 SHALL accept one sample every cycle, with no backpressure.
REQ-020 SHALL forward the stage-2 result to stage 1 when consecutive samples target the same channel, so each sample sees the fully updated y[c].
REQ-021 SHALL leave all state unchanged and deassert out_valid when in_valid is low; out_sample and out_channel SHALL hold their last values.
REQ-022 SHALL set y[c] to 0 and p[c] to 0 on a clear_mask[c] cycle.
REQ-023 SHALL give clear priority when a clear and a stage-2 write hit the same channel in the same cycle: the write is suppressed, but out_valid and out_sample are still emitted.
REQ-024 SHALL treat a sample entering stage 1 in the same cycle as clear_mask[c] as following the clear (y[c] = 0, unprimed).
REQ-025 SHALL, for in_channel >= CHANNELS, accept the sample, produce no output and make no state change.

Reset
REQ-026 SHALL, while reset is high, force all y[c] to 0, all p[c] to 0, both pipeline valids to 0, out_valid to 0, out_sample to 0 and out_channel to 0.
REQ-027 SHALL discard in-flight samples when reset occurs mid-pipeline; no out_valid SHALL appear for them after reset releases.

Configuration
REQ-028 SHALL use macro IIR_FILTER_PRIME_EN to control first-sample priming.
REQ-029 SHALL, when IIR_FILTER_PRIME_EN is defined, make the first accepted sample on an unprimed channel set y[c] = x, output x and set p[c] = 1; later samples follow REQ-015.
REQ-030 SHALL, when IIR_FILTER_PRIME_EN is undefined, omit the primed flags and apply REQ-015 to every sample, starting from y[c] = 0.

Verification (WIDTH=16, CHANNELS=4, SHIFT=4)
REQ-031 SHALL test priming with the macro defined: reset, then ch0 inputs 1600, then 0 -> outputs 1600, then 1500, each 2 cycles after its input.
REQ-032 SHALL test the no-priming path with the macro undefined: reset, then ch0 input 1600 -> output 100.
REQ-033 SHALL test back-to-back forwarding with the macro undefined: ch1 inputs 160, 160 on consecutive cycles -> outputs 10, then 19 on consecutive cycles.
REQ-034 SHALL test floor shift and extremes: y=0, x=-1 -> output -1; y=-32768, x=32767 -> output -28673, with no wrap.
REQ-035 SHALL test interleave and clear: ch2/ch3 alternating each cycle stay independent; clear_mask[2] in the cycle ch2's stage-2 write lands -> output emitted, y[2] reads back 0, next ch2 sample follows the unprimed rule.
REQ-036 SHALL test reset mid-flight: assert reset one cycle after in_valid -> no out_valid after release and all outputs 0.
